// File: rtl/sample_responder.sv
// EBI-mapped sample responder: decimates converter strobes, captures samples with
// a sequence number and hands them to a polling collector over an OR-able bus.
module sample_responder #(
  parameter logic [7:0] POSITION = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [31:0] ebi_data_in,
  input  logic        cs,
  input  logic        re,
  input  logic        wr,
  output logic [15:0] ebi_data_out,
  input  logic [12:0] raw_data,
  input  logic        raw_valid,
  input  logic [7:0]  channel_select,
  input  logic        output_sample,
  output logic [31:0] sample_data,
  output logic        sample_pending
);

  typedef enum logic [1:0] {STOPPED, WAIT_RAW, PENDING} state_t;

  localparam logic [7:0] A_CMD     = 8'h01;
  localparam logic [7:0] A_DECIM   = 8'h02;
  localparam logic [7:0] A_SEQ     = 8'h03;
  localparam logic [7:0] A_OVERRUN = 8'h04;
  localparam logic [7:0] A_STATUS  = 8'h05;
  localparam logic [7:0] A_DEBUG   = 8'h0A;

  state_t      state_q, state_d;
  logic        start_q, start_d, stop_q, stop_d, clear_q, clear_d;
  logic [15:0] decim_q, decim_d, cnt_q, cnt_d;
  logic [15:0] seq_q, seq_d, ovr_q, ovr_d;
  logic [12:0] data_q, data_d;
  logic [31:0] shadow_q, shadow_d;
  logic        sel_os_q, sel_os_d;
  logic [15:0] ebi_q, ebi_d;

  logic selected, reg_access, wr_en, rd_en, running, accept, fetch, sel_os;

  assign selected   = (channel_select == POSITION);
  assign reg_access = cs & (addr[15:8] == POSITION);
  assign wr_en      = reg_access & wr;
  assign rd_en      = reg_access & re;
  assign running    = (state_q != STOPPED);
  assign accept     = raw_valid & running & (cnt_q == decim_q);
  assign sel_os     = output_sample & selected;
  assign fetch      = sel_os & ~sel_os_q;

  always_comb begin
    state_d  = state_q;
    decim_d  = decim_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    ovr_d    = ovr_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    sel_os_d = sel_os;
    ebi_d    = 16'h0;

    // Commands are latched on the write and executed on the following edge.
    start_d = wr_en & (addr[7:0] == A_CMD) & (ebi_data_in == 32'd1);
    stop_d  = wr_en & (addr[7:0] == A_CMD) & (ebi_data_in == 32'd2);
    clear_d = wr_en & (addr[7:0] == A_CMD) & (ebi_data_in == 32'd5);
    if (wr_en && addr[7:0] == A_DECIM) decim_d = ebi_data_in[15:0];

    if (raw_valid && running) cnt_d = accept ? 16'h0 : cnt_q + 16'h1;
    if (fetch) shadow_d = {seq_q, 3'b000, data_q};

    case (state_q)
      STOPPED: if (start_q) state_d = WAIT_RAW;
      WAIT_RAW: begin
        if (stop_q) state_d = STOPPED;
        else if (accept) begin
          data_d  = raw_data;
          seq_d   = seq_q + 16'h1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (stop_q) state_d = STOPPED;
        else if (accept) begin
          data_d = raw_data;
          seq_d  = seq_q + 16'h1;
          if (!fetch && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'h1;
        end else if (fetch) state_d = WAIT_RAW;
      end
      default: state_d = STOPPED;
    endcase

    if (state_d == STOPPED && state_q != STOPPED) cnt_d = 16'h0;

    if (clear_q) begin
      state_d  = STOPPED;
      decim_d  = 16'h0;
      cnt_d    = 16'h0;
      seq_d    = 16'h0;
      ovr_d    = 16'h0;
      data_d   = 13'h0;
      shadow_d = 32'h0;
    end

    if (rd_en) begin
      case (addr[7:0])
        A_SEQ:     ebi_d = seq_q;
        A_OVERRUN: ebi_d = ovr_q;
        A_STATUS:  ebi_d = {14'b0, (state_q == PENDING), running};
        A_DEBUG:   ebi_d = 16'hBEEF;
        default:   ebi_d = 16'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STOPPED;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      clear_q  <= 1'b0;
      decim_q  <= 16'h0;
      cnt_q    <= 16'h0;
      seq_q    <= 16'h0;
      ovr_q    <= 16'h0;
      data_q   <= 13'h0;
      shadow_q <= 32'h0;
      sel_os_q <= 1'b0;
      ebi_q    <= 16'h0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      clear_q  <= clear_d;
      decim_q  <= decim_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      ovr_q    <= ovr_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      sel_os_q <= sel_os_d;
      ebi_q    <= ebi_d;
    end
  end

  assign ebi_data_out   = ebi_q;
  assign sample_data    = selected ? shadow_q : 32'h0;
  assign sample_pending = (state_q == PENDING);

endmodule

// File: tb/tb_sample_responder.sv
// Directed bench for sample_responder: EBI commands, decimation, overrun,
// fetch handshake, sequence wrap, clear and asynchronous reset.
module tb_sample_responder;
  localparam logic [7:0] POS = 8'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [31:0] ebi_data_in;
  logic        cs, re, wr;
  logic [15:0] ebi_data_out;
  logic [12:0] raw_data;
  logic        raw_valid;
  logic [7:0]  channel_select;
  logic        output_sample;
  logic [31:0] sample_data;
  logic        sample_pending;

  int pass_cnt = 0;
  int total_cnt = 0;

  sample_responder #(.POSITION(POS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .ebi_data_in(ebi_data_in),
    .cs(cs), .re(re), .wr(wr), .ebi_data_out(ebi_data_out),
    .raw_data(raw_data), .raw_valid(raw_valid), .channel_select(channel_select),
    .output_sample(output_sample), .sample_data(sample_data),
    .sample_pending(sample_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Register write plus one idle edge so a CMD has taken effect on return.
  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    addr = {POS, a}; ebi_data_in = d; cs = 1'b1; wr = 1'b1;
    @(posedge clk); @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic rd_reg(input logic [7:0] unit, input logic [7:0] a,
                        input logic [15:0] exp, input string tag);
    addr = {unit, a}; cs = 1'b1; re = 1'b1;
    @(posedge clk); @(negedge clk);
    chk(tag, {16'h0, ebi_data_out}, {16'h0, exp});
    cs = 1'b0; re = 1'b0;
  endtask

  task automatic raw(input logic [12:0] d);
    raw_data = d; raw_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    raw_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] exp, input string tag);
    output_sample = 1'b1;
    @(posedge clk); @(negedge clk);
    chk(tag, sample_data, exp);
    output_sample = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; addr = 16'h0; ebi_data_in = 32'h0; cs = 1'b0; re = 1'b0; wr = 1'b0;
    raw_data = 13'h0; raw_valid = 1'b0; channel_select = POS; output_sample = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_sample_data", sample_data, 32'h0);
    chk("rst_pending", {31'h0, sample_pending}, 32'h0);
    chk("rst_ebi", {16'h0, ebi_data_out}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Strobes while stopped are ignored.
    raw(13'h123);
    chk("stopped_ignores_raw", {31'h0, sample_pending}, 32'h0);
    rd_reg(POS, 8'h03, 16'h0000, "stopped_seq");

    // Basic capture and fetch.
    wr_reg(8'h01, 32'd1);
    rd_reg(POS, 8'h05, 16'h0001, "status_running");
    raw(13'h0ABC);
    chk("pending_after_raw", {31'h0, sample_pending}, 32'h1);
    output_sample = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("fetch_basic", sample_data, 32'h0001_0ABC);
    chk("pending_cleared", {31'h0, sample_pending}, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("held_no_refetch", sample_data, 32'h0001_0ABC);
    output_sample = 1'b0;
    @(posedge clk); @(negedge clk);
    channel_select = 8'h02; #1;
    chk("deselect_zero", sample_data, 32'h0);
    channel_select = POS; #1;
    chk("reselect_shadow_kept", sample_data, 32'h0001_0ABC);

    // Decimation by 3.
    wr_reg(8'h01, 32'd5);
    wr_reg(8'h02, 32'd2);
    wr_reg(8'h01, 32'd1);
    for (int i = 1; i <= 6; i++) raw(13'(i));
    rd_reg(POS, 8'h03, 16'h0002, "decim_seq");
    fetch(32'h0002_0006, "decim_data");

    // Overrun.
    wr_reg(8'h01, 32'd5);
    wr_reg(8'h01, 32'd1);
    raw(13'h111); raw(13'h222); raw(13'h333);
    rd_reg(POS, 8'h04, 16'h0002, "overrun_2");
    rd_reg(POS, 8'h05, 16'h0003, "status_pending");
    fetch(32'h0003_0333, "overrun_fetch");

    // Same-cycle fetch and accepted raw.
    raw(13'h044);
    raw_data = 13'h055; raw_valid = 1'b1; output_sample = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("simul_shadow_old", sample_data, 32'h0004_0044);
    chk("simul_pending", {31'h0, sample_pending}, 32'h1);
    raw_valid = 1'b0; output_sample = 1'b0;
    @(posedge clk); @(negedge clk);
    rd_reg(POS, 8'h04, 16'h0002, "simul_overrun_same");
    fetch(32'h0005_0055, "simul_next_fetch");
    chk("simul_pending_clr", {31'h0, sample_pending}, 32'h0);

    // Stop returns to STOPPED.
    wr_reg(8'h01, 32'd2);
    rd_reg(POS, 8'h05, 16'h0000, "stop_status");

    // Sequence wrap and overrun saturation via continuous strobes.
    wr_reg(8'h01, 32'd5);
    wr_reg(8'h01, 32'd1);
    raw_data = 13'h0001; raw_valid = 1'b1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    @(negedge clk);
    raw_valid = 1'b0;
    rd_reg(POS, 8'h03, 16'hFFFF, "seq_ffff");
    rd_reg(POS, 8'h04, 16'hFFFE, "overrun_fffe");
    raw(13'h0002);
    rd_reg(POS, 8'h03, 16'h0000, "seq_wrap");
    rd_reg(POS, 8'h04, 16'hFFFF, "overrun_ffff");
    raw(13'h0003);
    rd_reg(POS, 8'h04, 16'hFFFF, "overrun_saturate");

    // Clear mid-PENDING.
    wr_reg(8'h01, 32'd5);
    chk("clear_pending", {31'h0, sample_pending}, 32'h0);
    rd_reg(POS, 8'h03, 16'h0000, "clear_seq");
    rd_reg(POS, 8'h04, 16'h0000, "clear_overrun");
    rd_reg(POS, 8'h05, 16'h0000, "clear_status");
    fetch(32'h0, "clear_shadow");
    rd_reg(POS, 8'h0A, 16'hBEEF, "debug");
    rd_reg(POS, 8'h07, 16'h0000, "unmapped");
    rd_reg(8'h02, 8'h0A, 16'h0000, "other_unit");

    // Asynchronous reset while PENDING and selected.
    wr_reg(8'h01, 32'd1);
    raw(13'h0AA);
    fetch(32'h0001_00AA, "pre_rst_fetch");
    raw(13'h0BB);
    addr = {POS, 8'h0A}; cs = 1'b1; re = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_ebi", {16'h0, ebi_data_out}, 32'h0000_BEEF);
    chk("pre_rst_pending", {31'h0, sample_pending}, 32'h1);
    #2 rst = 1'b1; #1;
    chk("async_rst_sample", sample_data, 32'h0);
    chk("async_rst_pending", {31'h0, sample_pending}, 32'h0);
    chk("async_rst_ebi", {16'h0, ebi_data_out}, 32'h0);
    cs = 1'b0; re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    raw(13'h0CC);
    chk("post_rst_stopped", {31'h0, sample_pending}, 32'h0);
    rd_reg(POS, 8'h03, 16'h0000, "post_rst_seq");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
